// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package serial_addsub_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_addsub_slice.sv
// 4-bit add/sub slice, purely combinational; b is inverted when sub=1, carry-in comes in separately.
// Exposes the carry into bit 3 so the caller can derive signed overflow at the MSB slice.
module nibble_addsub_slice
  import serial_addsub_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [NIB_W-1:0] bx;
  logic [NIB_W-2:0] lo;
  logic             s_hi;

  assign bx = b ^ {NIB_W{sub}};

  // Split at bit 3 so the carry into the MSB is available separately.
  assign {c_msb, lo} = {1'b0, a[NIB_W-2:0]} + {1'b0, bx[NIB_W-2:0]}
                     + {{(NIB_W-1){1'b0}}, cin};
  assign {cout, s_hi} = {1'b0, a[NIB_W-1]} + {1'b0, bx[NIB_W-1]} + {1'b0, c_msb};
  assign s = {s_hi, lo};

endmodule

// File: rtl/serial_addsub_ctrl.sv
// W-bit add/sub over NIBBLES cycles through one 4-bit slice; done pulses NIBBLES+1 cycles after start.
// start is ignored while busy (no queueing); a start in the done cycle is accepted back-to-back.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [NIB_W*NIBBLES-1:0] op_a,
  input  logic [NIB_W*NIBBLES-1:0] op_b,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] result,
  output logic                     cout,
  output logic                     overflow
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sub_q;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [NIB_W-1:0] s_nib;
  logic             s_cout;
  logic             s_cmsb;
  logic [W-1:0]     s_top;
  logic             last;

  nibble_addsub_slice u_slice (
    .a     (a_q[NIB_W-1:0]),
    .b     (b_q[NIB_W-1:0]),
    .sub   (sub_q),
    .cin   (carry),
    .s     (s_nib),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  // Each slice result enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  assign s_top = W'(s_nib) << (W - NIB_W);
  assign last  = (idx == IW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sub_q <= sub;
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result <= (result >> NIB_W) | s_top;
          a_q    <= a_q >> NIB_W;
          b_q    <= b_q >> NIB_W;
          carry  <= s_cout;
          idx    <= idx + IW'(1);
          if (last) begin
            cout     <= s_cout;
            overflow <= s_cmsb ^ s_cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed and random checks of serial_addsub_ctrl (16-bit and 4-bit builds) against an arithmetic model.
module tb_serial_addsub_ctrl;

  logic        clk;
  logic        rst_n;

  logic        start, sub;
  logic [15:0] op_a, op_b;
  logic        busy, done, cout, overflow;
  logic [15:0] result;

  logic        start1, sub1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, cout1, ovf1;
  logic [3:0]  result1;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  serial_addsub_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .op_a(a1), .op_b(b1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .overflow(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic and two's-complement sign rules.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic s, output logic [15:0] r, output logic c,
                                output logic o);
    int unsigned mask, ai, bi, rr;
    logic sa, sb, sr;
    mask = (32'd1 << w) - 32'd1;
    ai   = 32'(a) & mask;
    bi   = 32'(b) & mask;
    rr   = s ? ((ai - bi) & mask) : ((ai + bi) & mask);
    r    = rr[15:0];
    c    = s ? (ai >= bi) : ((ai + bi) > mask);
    sa   = ai[w-1];
    sb   = bi[w-1];
    sr   = rr[w-1];
    o    = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endfunction

  task automatic launch4(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input bit poke, input bit chain);
    logic [15:0] er;
    logic ec, eo;
    int cyc, bcnt;
    bit got;
    model(16, a, b, s, er, ec, eo);
    cyc = 0; bcnt = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) got = 1;
      if (poke && cyc == 2) begin
        start = 1'b1; op_a = 16'hDEAD; op_b = 16'hBEEF; sub = ~s;
      end else if (poke && cyc == 3) begin
        start = 1'b0;
      end
    end
    chk({tag, ".done_seen"}, 32'(got), 32'd1);
    chk({tag, ".latency"}, cyc, 5);
    chk({tag, ".busy_cycles"}, bcnt, 4);
    chk({tag, ".result"}, 32'(result), 32'(er));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    if (!chain) begin
      @(negedge clk);
      chk({tag, ".pulse_end"}, {30'd0, done, busy}, 32'd0);
      chk({tag, ".result_held"}, 32'(result), 32'(er));
    end
  endtask

  task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic s);
    launch4(a, b, s);
    wait4(tag, a, b, s, 1'b0, 1'b0);
  endtask

  task automatic op1(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic s);
    logic [15:0] er;
    logic ec, eo;
    int cyc, bcnt;
    bit got;
    model(4, 16'(a), 16'(b), s, er, ec, eo);
    @(negedge clk);
    a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
    cyc = 0; bcnt = 0; got = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (busy1 === 1'b1) bcnt++;
      if (done1 === 1'b1) got = 1;
    end
    chk({tag, ".done_seen"}, 32'(got), 32'd1);
    chk({tag, ".latency"}, cyc, 2);
    chk({tag, ".busy_cycles"}, bcnt, 1);
    chk({tag, ".result"}, 32'(result1), 32'(er));
    chk({tag, ".cout"}, 32'(cout1), 32'(ec));
    chk({tag, ".overflow"}, 32'(ovf1), 32'(eo));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic rs;
    int sel;
    bit saw_done;

    rst_n = 1'b0;
    start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("reset.dut4", {27'd0, busy, done, cout, overflow, |result}, 32'd0);
    chk("reset.dut1", {27'd0, busy1, done1, cout1, ovf1, |result1}, 32'd0);
    rst_n = 1'b1;

    op4("add_basic", 16'h1234, 16'h0FCD, 1'b0);
    op4("sub_borrow", 16'h0005, 16'h0007, 1'b1);
    op4("sub_noborrow", 16'h0007, 16'h0005, 1'b1);
    op4("ovf_add", 16'h7FFF, 16'h0001, 1'b0);
    op4("ovf_sub", 16'h8000, 16'h0001, 1'b1);
    op4("wrap_add", 16'hFFFF, 16'h0001, 1'b0);

    // Asynchronous reset in the third RUN cycle.
    launch4(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.outputs", {27'd0, busy, done, cout, overflow, |result}, 32'd0);
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    chk("abort.no_done", 32'(saw_done), 32'd0);
    rst_n = 1'b1;
    op4("after_reset", 16'h00FF, 16'h0001, 1'b0);

    // A start during RUN must not disturb the operation in flight.
    launch4(16'h1111, 16'h2222, 1'b0);
    wait4("start_ignored", 16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0);

    // Start held in the done cycle is accepted immediately.
    launch4(16'h4321, 16'h1234, 1'b1);
    wait4("b2b_first", 16'h4321, 16'h1234, 1'b1, 1'b0, 1'b1);
    op_a = 16'h0001; op_b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait4("b2b_second", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

    op1("n1_sub", 4'h9, 4'h3, 1'b1);
    for (int i = 0; i < 8; i++)
      op1("n1_rand", 4'($urandom), 4'($urandom), 1'($urandom));

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rs  = 1'($urandom);
      if (sel == 0) ra = {ra[15], 15'h7FFF};
      if (sel == 1) rb = ra;
      op4("rand", ra, rb, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
